// File: rtl/exception_sequencer.sv
// Exception sequencer: picks the oldest exception, captures EPC/cause, redirects fetch and flushes the pipe.
// Latency: redirect and flushes are combinational in the detection cycle, status registers update next cycle; no backpressure.
module exception_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_FFFC,
    parameter int          WDOG_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        undef_id,
    input  logic        eret_id,
    input  logic [31:0] id_pc,
    input  logic        squash_id,
    input  logic        ovf_ex,
    input  logic [31:0] ex_pc,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc_target,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        in_handler,
    output logic        double_fault,
    output logic [7:0]  exc_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HANDLER = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [1:0]  SEL_SEQ     = 2'b00;
    localparam logic [1:0]  SEL_HANDLER = 2'b01;
    localparam logic [1:0]  SEL_EPC     = 2'b10;
    localparam logic [1:0]  SEL_HOLD    = 2'b11;
    localparam logic [1:0]  CAUSE_NONE  = 2'b00;
    localparam logic [1:0]  CAUSE_UNDEF = 2'b01;
    localparam logic [1:0]  CAUSE_ARITH = 2'b10;
    localparam logic [15:0] WDOG_LAST   = 16'(WDOG_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] wdog;
    logic        ev_o, ev_u, ev_r, wdog_hit;
    logic        take_o, take_u, do_ret;

    assign ev_o     = ovf_ex;
    assign ev_u     = (undef_id | (eret_id & (state == S_IDLE))) & ~squash_id;
    assign ev_r     = eret_id & ~squash_id & (state == S_HANDLER);
    assign wdog_hit = (wdog == WDOG_LAST);

    always_comb begin
        state_nxt    = state;
        pc_sel       = SEL_SEQ;
        pc_target    = 32'd0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        take_o       = 1'b0;
        take_u       = 1'b0;
        do_ret       = 1'b0;
        case (state)
            S_IDLE: begin
                // EX is older than ID, so overflow wins and the ID instruction is flushed with it
                if (ev_o) begin
                    pc_sel       = SEL_HANDLER;
                    pc_target    = HANDLER_ADDR;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    take_o       = 1'b1;
                    state_nxt    = S_HANDLER;
                end else if (ev_u) begin
                    pc_sel      = SEL_HANDLER;
                    pc_target   = HANDLER_ADDR;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    take_u      = 1'b1;
                    state_nxt   = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (ev_o || ev_u || (wdog_hit && !ev_r)) begin
                    pc_sel       = SEL_HOLD;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    state_nxt    = S_HALT;
                end else if (ev_r) begin
                    pc_sel      = SEL_EPC;
                    pc_target   = epc;
                    flush_if_id = 1'b1;
                    do_ret      = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                pc_sel       = SEL_HOLD;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                state_nxt    = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            epc          <= 32'd0;
            cause        <= CAUSE_NONE;
            exc_count    <= 8'd0;
            wdog         <= 16'd0;
            double_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_o || take_u) begin
                epc   <= take_o ? ex_pc : id_pc;
                cause <= take_o ? CAUSE_ARITH : CAUSE_UNDEF;
                if (exc_count != 8'hFF) begin
                    exc_count <= exc_count + 8'd1;
                end
            end else if (do_ret) begin
                cause <= CAUSE_NONE;
            end
            // Counts only while staying in the handler; any entry starts from zero
            if (state == S_HANDLER && state_nxt == S_HANDLER) begin
                wdog <= wdog + 16'd1;
            end else begin
                wdog <= 16'd0;
            end
            if (state_nxt == S_HALT) begin
                double_fault <= 1'b1;
            end
        end
    end

    assign in_handler = (state == S_HANDLER);

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        undef_id = 1'b0;
    logic        eret_id = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic        squash_id = 1'b0;
    logic        ovf_ex = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_handler, double_fault;
    logic [7:0]  exc_count;

    int errors = 0;
    int checks = 0;

    exception_sequencer #(.HANDLER_ADDR(32'h0000_FFFC), .WDOG_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .undef_id(undef_id), .eret_id(eret_id), .id_pc(id_pc), .squash_id(squash_id),
        .ovf_ex(ovf_ex), .ex_pc(ex_pc),
        .pc_sel(pc_sel), .pc_target(pc_target),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .epc(epc), .cause(cause), .in_handler(in_handler),
        .double_fault(double_fault), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; everything is sampled 1 unit later
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        undef_id = 1'b0; eret_id = 1'b0; squash_id = 1'b0; ovf_ex = 1'b0;
    endtask

    task automatic chk_flush(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, {29'd0, exp});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, {30'd0, pc_sel}, 32'd0);
        chk({tag, "_tgt"}, pc_target, 32'd0);
        chk_flush({tag, "_flush"}, 3'b000);
        chk({tag, "_epc"}, epc, 32'd0);
        chk({tag, "_cause"}, {30'd0, cause}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, exc_count}, 32'd0);
        chk({tag, "_inh"}, {31'd0, in_handler}, 32'd0);
        chk({tag, "_df"}, {31'd0, double_fault}, 32'd0);
    endtask

    initial begin
        #12;
        chk_reset_vals("rst");
        step();
        reset = 1'b1;
        step();

        // Undefined opcode in IDLE
        undef_id = 1'b1; id_pc = 32'h40;
        #1;
        chk("u_sel", {30'd0, pc_sel}, 32'd1);
        chk("u_tgt", pc_target, 32'h0000_FFFC);
        chk_flush("u_flush", 3'b110);
        step(); idle_inputs(); #1;
        chk("u_epc", epc, 32'h40);
        chk("u_cause", {30'd0, cause}, 32'd1);
        chk("u_inh", {31'd0, in_handler}, 32'd1);
        chk("u_cnt", {24'd0, exc_count}, 32'd1);
        chk("h_quiet_sel", {30'd0, pc_sel}, 32'd0);

        // Squashed eret is ignored, then a real eret returns to EPC
        step(); eret_id = 1'b1; squash_id = 1'b1; #1;
        chk("sq_eret_sel", {30'd0, pc_sel}, 32'd0);
        chk_flush("sq_eret_flush", 3'b000);
        step(); squash_id = 1'b0; #1;
        chk("r_inh_before", {31'd0, in_handler}, 32'd1);
        chk("r_sel", {30'd0, pc_sel}, 32'd2);
        chk("r_tgt", pc_target, 32'h40);
        chk_flush("r_flush", 3'b100);
        step(); idle_inputs(); #1;
        chk("r_cause", {30'd0, cause}, 32'd0);
        chk("r_inh", {31'd0, in_handler}, 32'd0);
        chk("r_epc", epc, 32'h40);

        // Overflow and undefined in the same cycle: overflow wins
        step(); ovf_ex = 1'b1; ex_pc = 32'h3C; undef_id = 1'b1; id_pc = 32'h40; #1;
        chk("ou_sel", {30'd0, pc_sel}, 32'd1);
        chk_flush("ou_flush", 3'b111);
        step(); idle_inputs(); #1;
        chk("ou_epc", epc, 32'h3C);
        chk("ou_cause", {30'd0, cause}, 32'd2);
        chk("ou_cnt", {24'd0, exc_count}, 32'd2);
        eret_id = 1'b1;
        step(); idle_inputs(); #1;
        chk("ou_ret_inh", {31'd0, in_handler}, 32'd0);

        // Squashed undefined in IDLE does nothing
        undef_id = 1'b1; squash_id = 1'b1; #1;
        chk("squ_sel", {30'd0, pc_sel}, 32'd0);
        chk_flush("squ_flush", 3'b000);
        step(); idle_inputs(); #1;
        chk("squ_inh", {31'd0, in_handler}, 32'd0);
        chk("squ_cnt", {24'd0, exc_count}, 32'd2);

        // eret in IDLE is an undefined-instruction exception
        eret_id = 1'b1; id_pc = 32'h80; #1;
        chk("ie_sel", {30'd0, pc_sel}, 32'd1);
        chk_flush("ie_flush", 3'b110);
        step(); idle_inputs(); #1;
        chk("ie_cause", {30'd0, cause}, 32'd1);
        chk("ie_epc", epc, 32'h80);
        chk("ie_cnt", {24'd0, exc_count}, 32'd3);

        // Watchdog: fires on the 4th handler cycle without eret
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_sel%0d", i), {30'd0, pc_sel}, (i == 3) ? 32'd3 : 32'd0);
            step();
        end
        chk("wd_df", {31'd0, double_fault}, 32'd1);
        chk("wd_inh", {31'd0, in_handler}, 32'd0);
        chk("wd_halt_sel", {30'd0, pc_sel}, 32'd3);
        chk_flush("wd_halt_flush", 3'b111);
        chk("wd_epc", epc, 32'h80);
        chk("wd_cause", {30'd0, cause}, 32'd1);
        ovf_ex = 1'b1; eret_id = 1'b1;
        step(); idle_inputs(); #1;
        chk("halt_sel", {30'd0, pc_sel}, 32'd3);
        chk("halt_cnt", {24'd0, exc_count}, 32'd3);
        chk("halt_df", {31'd0, double_fault}, 32'd1);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b0; #1;
        chk_reset_vals("arst");
        step(); reset = 1'b1; step();

        // Overflow inside the handler is a nested exception
        undef_id = 1'b1; id_pc = 32'h100;
        step(); idle_inputs(); ovf_ex = 1'b1; ex_pc = 32'h200; #1;
        chk("nest_sel", {30'd0, pc_sel}, 32'd3);
        chk_flush("nest_flush", 3'b111);
        step(); idle_inputs(); #1;
        chk("nest_df", {31'd0, double_fault}, 32'd1);
        chk("nest_epc", epc, 32'h100);
        chk("nest_cause", {30'd0, cause}, 32'd1);
        chk("nest_cnt", {24'd0, exc_count}, 32'd1);
        reset = 1'b0; #1;
        chk_reset_vals("rst2");
        step(); reset = 1'b1; step();

        // 256 exception/eret pairs saturate the counter
        for (int i = 0; i < 256; i++) begin
            undef_id = 1'b1; id_pc = 32'(i * 4);
            step(); idle_inputs(); eret_id = 1'b1;
            step(); idle_inputs();
            if (i == 254) chk("sat_255", {24'd0, exc_count}, 32'd255);
        end
        #1;
        chk("sat_hold", {24'd0, exc_count}, 32'd255);
        chk("sat_inh", {31'd0, in_handler}, 32'd0);
        chk("sat_df", {31'd0, double_fault}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Centralised exception controller for the dual-lane (R/S) five-stage pipeline. Detects undefined-opcode (ID) and arithmetic-overflow (EX) events, selects the architecturally oldest one, captures EPC and cause, redirects fetch to the handler, and emits per-stage flushes. Also sequences return-from-exception and enforces a handler watchdog with a double-fault halt. Sits beside the hazard unit, driving the PC-select mux and pipeline-register flush inputs.

## Interface
Parameters:
- HANDLER_ADDR, 32'h0000_FFFC, exception vector address
- WDOG_CYCLES, 256, max cycles in handler before double fault (≥2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- undef_id  in  1  control decoder flags undefined opcode in ID
- eret_id  in  1  return-from-exception decoded in ID
- id_pc  in  32  PC of instruction in ID
- squash_id  in  1  ID instruction is wrong-path (taken branch/jump); masks undef_id, eret_id
- ovf_ex  in  1  ALU signed overflow in EX
- ex_pc  in  32  PC of instruction in EX
- pc_sel  out  2  00 sequential, 01 handler, 10 EPC, 11 hold
- pc_target  out  32  redirect address (0 when pc_sel=00)
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  squash corresponding pipeline register
- epc  out  32  captured exception PC
- cause  out  2  00 none, 01 undefined, 10 arithmetic
- in_handler  out  1  high in HANDLER state
- double_fault  out  1  sticky; high in HALT
- exc_count  out  8  exceptions taken, saturating

## Operation
- States: IDLE, HANDLER, HALT. Reset → IDLE.
- Qualified events: U = (undef_id | (eret_id & state==IDLE)) & !squash_id; R = eret_id & !squash_id & state==HANDLER; O = ovf_ex.
- Priority: O > U (EX instruction is older). Same-cycle O and U → only O taken.
- IDLE, O: pc_sel=01, pc_target=HANDLER_ADDR, all three flushes=1 (overflowing instruction suppressed); edge: epc←ex_pc, cause←10, exc_count+1 (saturate 255), → HANDLER.
- IDLE, U (no O): pc_sel=01, pc_target=HANDLER_ADDR, flush_if_id=flush_id_ex=1, flush_ex_mem=0 (older EX instruction retires); edge: epc←id_pc, cause←01, count+1, → HANDLER.
- eret in IDLE is illegal: treated as U (cause 01).
- HANDLER, R (no O): pc_sel=10, pc_target=epc, flush_if_id=1; edge: cause←00, epc retained, → IDLE.
- HANDLER, O or U: nested exception → double fault: pc_sel=11, all flushes=1; edge: double_fault←1, → HALT. epc/cause/count unchanged. O beats R same cycle.
- HANDLER watchdog: 16-bit counter cleared on entry, increments each HANDLER cycle; reaching WDOG_CYCLES-1 without R → double fault as above.
- HALT: pc_sel=11, all flushes=1 every cycle; exits only on reset. Inputs ignored.
- squash_id never masks O.

## Timing
- pc_sel, pc_target, flushes are combinational (Mealy) in the detection cycle; zero latency to PC mux.
- epc, cause, exc_count, in_handler, double_fault are registered; visible one cycle after detection.
- Earliest eret accepted in the cycle after entry (in_handler=1).
- Reset (async, mid-operation included): state IDLE, epc=0, cause=00, exc_count=0, watchdog=0, double_fault=0, in_handler=0; combinational outputs pc_sel=00, pc_target=0, flushes=0.
- exc_count at 255 stays 255.

## Test plan
- undef_id=1, id_pc=0x40 in IDLE → same cycle pc_sel=01, pc_target=0xFFFC, flush_if_id/id_ex=1, flush_ex_mem=0; next cycle epc=0x40, cause=01, in_handler=1, exc_count=1.
- ovf_ex=1 (ex_pc=0x3C) and undef_id=1 (id_pc=0x40) same cycle → all flushes=1, epc=0x3C, cause=10, exc_count=1.
- In HANDLER, eret_id=1 → pc_sel=10, pc_target=epc, flush_if_id=1; next cycle cause=00, in_handler=0; eret_id with squash_id=1 ignored.
- undef_id with squash_id=1 in IDLE → no flush, pc_sel=00, state unchanged; eret_id in IDLE → cause=01.
- In HANDLER, no eret for WDOG_CYCLES (use 4) → double_fault=1, pc_sel=11 persistently; ovf_ex in HANDLER → same; reset deasserted after assertion → all outputs at reset values.
- 256 exception/eret pairs → exc_count saturates at 255.
